polygon_query_scheduler: RTL and testbench

- Shares one pipelined point-in-polygon checker among NUM_POLYS stored polygons (terrain, car body, obstacles).
- Accepts a query point over a valid/ready handshake. Issues one checker request per enabled polygon on consecutive cycles, and collects the returning hit bits into a mask.
- Returns hit, lowest hit index and the full mask over a valid/ready result handshake.
- Sits between the physics/render logic and the shared in_polygon instance plus its polygon bank mux, which is driven by chk_sel_out.

---
 rtl/polygon_query_scheduler_if.sv | 45 ++++
 rtl/polygon_query_scheduler.sv | 174 +++++++++++++++++
 tb/tb_polygon_query_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/polygon_query_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | polygon_query_scheduler_if                                           |
// | Query, checker-request and result handshakes of the polygon          |
// | query scheduler.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface polygon_query_scheduler_if #(
  parameter int NUM_POLYS = 4,
  parameter int COORD_W   = 32
);
  localparam int c_num_w = $clog2(NUM_POLYS + 1);
  localparam int c_sel_w = (NUM_POLYS > 1) ? $clog2(NUM_POLYS) : 1;

  logic                      query_valid_in;
  logic                      query_ready_out;
  logic signed [COORD_W-1:0] x_in;
  logic signed [COORD_W-1:0] y_in;
  logic [c_num_w-1:0]        num_polys_in;

  logic                      chk_valid_out;
  logic [c_sel_w-1:0]        chk_sel_out;
  logic signed [COORD_W-1:0] chk_x_out;
  logic signed [COORD_W-1:0] chk_y_out;
  logic                      chk_hit_in;

  logic                      result_valid_out;
  logic                      result_ready_in;
  logic                      hit_out;
  logic [c_sel_w-1:0]        hit_idx_out;
  logic [NUM_POLYS-1:0]      hit_mask_out;

  modport slave (
    input  query_valid_in, x_in, y_in, num_polys_in, chk_hit_in, result_ready_in,
    output query_ready_out, chk_valid_out, chk_sel_out, chk_x_out, chk_y_out,
           result_valid_out, hit_out, hit_idx_out, hit_mask_out
  );

  modport master (
    output query_valid_in, x_in, y_in, num_polys_in, chk_hit_in, result_ready_in,
    input  query_ready_out, chk_valid_out, chk_sel_out, chk_x_out, chk_y_out,
           result_valid_out, hit_out, hit_idx_out, hit_mask_out
  );
endinterface
`default_nettype wire

// File: rtl/polygon_query_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | polygon_query_scheduler                                              |
// | Fans one query point out to a shared pipelined point-in-polygon      |
// | checker, one request per polygon, and gathers the hit mask.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module polygon_query_scheduler #(
  parameter int NUM_POLYS   = 4,
  parameter int CHK_LATENCY = 2,
  parameter int COORD_W     = 32
) (
  input  wire logic                clk_in,
  input  wire logic                rst_in,
  polygon_query_scheduler_if.slave bus
);
  localparam int c_sel_w = (NUM_POLYS > 1) ? $clog2(NUM_POLYS) : 1;
  localparam int c_cnt_w = $clog2(NUM_POLYS + CHK_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_query_ready;
  logic                      r_chk_valid;
  logic [c_sel_w-1:0]        r_chk_sel;
  logic signed [COORD_W-1:0] r_chk_x;
  logic signed [COORD_W-1:0] r_chk_y;
  logic                      r_result_valid;
  logic                      r_hit;
  logic [c_sel_w-1:0]        r_hit_idx;
  logic [NUM_POLYS-1:0]      r_hit_mask;
  logic [NUM_POLYS-1:0]      r_mask;
  logic [c_cnt_w-1:0]        r_n;
  logic [c_cnt_w-1:0]        r_ret_cnt;
  logic [CHK_LATENCY-1:0]    r_sr_valid;
  logic [c_sel_w-1:0]        r_sr_sel [CHK_LATENCY];

  logic                      w_head_valid;
  logic [c_sel_w-1:0]        w_head_sel;
  logic [c_cnt_w-1:0]        w_n;
  logic [c_cnt_w-1:0]        w_ret_next;
  logic                      w_last_issue;
  logic [NUM_POLYS-1:0]      w_mask_next;
  logic [c_sel_w-1:0]        w_idx_next;

  assign w_head_valid = r_sr_valid[CHK_LATENCY-1];
  assign w_head_sel   = r_sr_sel[CHK_LATENCY-1];
  assign w_ret_next   = r_ret_cnt + c_cnt_w'(w_head_valid);
  assign w_last_issue = ((c_cnt_w'(r_chk_sel) + c_cnt_w'(1)) == r_n);

  always_comb begin
    w_n = c_cnt_w'(bus.num_polys_in);
    if (w_n > c_cnt_w'(NUM_POLYS)) begin
      w_n = c_cnt_w'(NUM_POLYS);
    end
  end

  // Mask including this cycle's returning hit, so DONE can be entered on the final return.
  always_comb begin
    w_mask_next = r_mask;
    for (int i = 0; i < NUM_POLYS; i++) begin
      if (w_head_valid && (w_head_sel == c_sel_w'(i))) begin
        w_mask_next[i] = bus.chk_hit_in;
      end
    end
    w_idx_next = '0;
    for (int i = NUM_POLYS - 1; i >= 0; i--) begin
      if (w_mask_next[i]) begin
        w_idx_next = c_sel_w'(i);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= ST_IDLE;
      r_query_ready  <= 1'b0;
      r_chk_valid    <= 1'b0;
      r_chk_sel      <= '0;
      r_chk_x        <= '0;
      r_chk_y        <= '0;
      r_result_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_hit_idx      <= '0;
      r_hit_mask     <= '0;
      r_mask         <= '0;
      r_n            <= '0;
      r_ret_cnt      <= '0;
      r_sr_valid     <= '0;
      for (int k = 0; k < CHK_LATENCY; k++) begin
        r_sr_sel[k] <= '0;
      end
    end else begin
      for (int k = CHK_LATENCY - 1; k > 0; k--) begin
        r_sr_valid[k] <= r_sr_valid[k-1];
        r_sr_sel[k]   <= r_sr_sel[k-1];
      end
      r_sr_valid[0] <= r_chk_valid;
      r_sr_sel[0]   <= r_chk_sel;
      r_mask        <= w_mask_next;
      r_ret_cnt     <= w_ret_next;

      case (r_state)
        ST_IDLE: begin
          r_query_ready <= 1'b1;
          if (bus.query_valid_in && r_query_ready) begin
            r_query_ready <= 1'b0;
            r_chk_x       <= bus.x_in;
            r_chk_y       <= bus.y_in;
            r_n           <= w_n;
            r_mask        <= '0;
            r_ret_cnt     <= '0;
            if (w_n == '0) begin
              r_state        <= ST_DONE;
              r_result_valid <= 1'b1;
              r_hit          <= 1'b0;
              r_hit_idx      <= '0;
              r_hit_mask     <= '0;
            end else begin
              r_state     <= ST_ISSUE;
              r_chk_valid <= 1'b1;
              r_chk_sel   <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (w_last_issue) begin
            r_chk_valid <= 1'b0;
            r_chk_sel   <= '0;
            r_state     <= ST_DRAIN;
          end else begin
            r_chk_sel <= r_chk_sel + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_ret_next == r_n) begin
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
            r_hit          <= |w_mask_next;
            r_hit_idx      <= w_idx_next;
            r_hit_mask     <= w_mask_next;
          end
        end
        ST_DONE: begin
          if (bus.result_ready_in) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
            r_query_ready  <= 1'b1;
            r_hit          <= 1'b0;
            r_hit_idx      <= '0;
            r_hit_mask     <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.query_ready_out  = r_query_ready;
  assign bus.chk_valid_out    = r_chk_valid;
  assign bus.chk_sel_out      = r_chk_sel;
  assign bus.chk_x_out        = r_chk_x;
  assign bus.chk_y_out        = r_chk_y;
  assign bus.result_valid_out = r_result_valid;
  assign bus.hit_out          = r_hit;
  assign bus.hit_idx_out      = r_hit_idx;
  assign bus.hit_mask_out     = r_hit_mask;
endmodule
`default_nettype wire

// File: tb/tb_polygon_query_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_polygon_query_scheduler                                           |
// | Directed scoreboard bench with a fixed-latency checker model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_polygon_query_scheduler;
  localparam int NUM_POLYS   = 4;
  localparam int CHK_LATENCY = 2;
  localparam int COORD_W     = 32;
  localparam int SW          = 2;
  localparam int NW          = 3;

  typedef struct {
    int                 cyc;
    logic [SW-1:0]      sel;
    logic signed [31:0] x;
    logic signed [31:0] y;
  } req_t;

  typedef struct {
    int                   cyc;
    logic                 hit;
    logic [SW-1:0]        idx;
    logic [NUM_POLYS-1:0] mask;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  req_t exp_req[$];
  res_t exp_res[$];

  logic [NUM_POLYS-1:0]   hits = '0;
  logic                   force_hit = 1'b0;
  bit   [CHK_LATENCY-1:0] pipe;

  polygon_query_scheduler_if #(.NUM_POLYS(NUM_POLYS), .COORD_W(COORD_W)) bus ();

  polygon_query_scheduler #(
    .NUM_POLYS  (NUM_POLYS),
    .CHK_LATENCY(CHK_LATENCY),
    .COORD_W    (COORD_W)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  // Checker model: answers each request exactly CHK_LATENCY cycles later.
  always @(negedge clk) begin
    bus.chk_hit_in = force_hit ? 1'b1 : pipe[CHK_LATENCY-1];
    for (int k = CHK_LATENCY - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = bus.chk_valid_out ? hits[bus.chk_sel_out] : 1'b0;
  end

  always @(negedge clk) begin
    req_t e;
    #1;
    if (bus.chk_valid_out) begin
      if (exp_req.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got sel=%0d at cycle %0d, required no request", bus.chk_sel_out, cyc);
      end else begin
        e = exp_req.pop_front();
        check("req_cycle", 64'(cyc), 64'(e.cyc));
        check("req_sel", 64'(bus.chk_sel_out), 64'(e.sel));
        check("req_x", 64'(bus.chk_x_out), 64'(e.x));
        check("req_y", 64'(bus.chk_y_out), 64'(e.y));
      end
    end
  end

  logic prev_valid = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    res_t e;
    #1;
    if (bus.result_valid_out && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.result_valid_out;
    if (bus.result_valid_out && bus.result_ready_in) begin
      if (exp_res.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got mask=%b at cycle %0d, required no result", bus.hit_mask_out, cyc);
      end else begin
        e = exp_res.pop_front();
        check("res_cycle", 64'(rise_cyc), 64'(e.cyc));
        check("res_hit", 64'(bus.hit_out), 64'(e.hit));
        check("res_idx", 64'(bus.hit_idx_out), 64'(e.idx));
        check("res_mask", 64'(bus.hit_mask_out), 64'(e.mask));
      end
    end
  end

  // Called just after a negedge; returns at the negedge of cycle 1 after the accept edge.
  task automatic issue_query(input int x, input int y, input int nin, input int n_req,
                             input bit want_res, input logic ehit, input int eidx,
                             input logic [NUM_POLYS-1:0] emask, input int lat, output int acc);
    int   w = 0;
    req_t r;
    res_t s;
    acc = -1;
    while (!bus.query_ready_out) begin
      if (w == 60) begin
        n_vec++;
        n_err++;
        $display("FAIL query_accept_timeout: got query_ready_out=0, required 1 within 60 cycles");
        return;
      end
      w++;
      @(negedge clk);
    end
    bus.query_valid_in = 1'b1;
    bus.x_in           = x;
    bus.y_in           = y;
    bus.num_polys_in   = NW'(nin);
    acc                = cyc + 1;
    for (int i = 0; i < n_req; i++) begin
      r.cyc = acc + i;
      r.sel = SW'(i);
      r.x   = x;
      r.y   = y;
      exp_req.push_back(r);
    end
    if (want_res) begin
      s.cyc  = acc + lat - 1;
      s.hit  = ehit;
      s.idx  = SW'(eidx);
      s.mask = emask;
      exp_res.push_back(s);
    end
    @(posedge clk);
    @(negedge clk);
    bus.query_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while (exp_req.size() != 0 || exp_res.size() != 0) begin
      if (w == budget) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: got %0d requests and %0d results pending, required 0", exp_req.size(), exp_res.size());
        exp_req.delete();
        exp_res.delete();
        return;
      end
      w++;
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int d;
    rst                 = 1'b1;
    bus.query_valid_in  = 1'b0;
    bus.x_in            = '0;
    bus.y_in            = '0;
    bus.num_polys_in    = '0;
    bus.result_ready_in = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_query_ready", 64'(bus.query_ready_out), 64'(0));
    check("rst_result_valid", 64'(bus.result_valid_out), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_query_ready", 64'(bus.query_ready_out), 64'(1));
    check("idle_result_valid", 64'(bus.result_valid_out), 64'(0));
    check("idle_chk_valid", 64'(bus.chk_valid_out), 64'(0));
    check("idle_mask", 64'(bus.hit_mask_out), 64'(0));

    hits = 4'b0110;
    issue_query(800, 200, 3, 3, 1'b1, 1'b1, 1, 4'b0110, 6, acc);
    wait_idle(40);

    @(negedge clk);
    hits = 4'b0000;
    issue_query(-1, -1, 0, 0, 1'b1, 1'b0, 0, 4'b0000, 1, acc);
    wait_idle(40);

    @(negedge clk);
    hits = 4'b1111;
    issue_query(-3, 7, 7, 4, 1'b1, 1'b1, 0, 4'b1111, 7, acc);
    wait_idle(40);

    @(negedge clk);
    hits = 4'b1000;
    issue_query(-5, -100000, 4, 4, 1'b1, 1'b1, 3, 4'b1000, 7, acc);
    wait_idle(40);

    // Result backpressure with a competing query pulsing.
    @(negedge clk);
    bus.result_ready_in = 1'b0;
    hits                = 4'b0001;
    issue_query(10, 20, 2, 2, 1'b1, 1'b1, 0, 4'b0001, 5, acc);
    d = 0;
    while (!bus.result_valid_out && d < 20) begin
      @(negedge clk);
      #1;
      d++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_result_valid", 64'(bus.result_valid_out), 64'(1));
      check("bp_query_ready", 64'(bus.query_ready_out), 64'(0));
      check("bp_mask", 64'(bus.hit_mask_out), 64'(4'b0001));
      check("bp_idx", 64'(bus.hit_idx_out), 64'(0));
      @(negedge clk);
      bus.query_valid_in = (k % 2 == 0);
      bus.x_in           = 77;
      bus.y_in           = 88;
      bus.num_polys_in   = NW'(1);
      #1;
    end
    @(negedge clk);
    bus.query_valid_in  = 1'b0;
    bus.result_ready_in = 1'b1;
    d = cyc;
    @(negedge clk);
    #2;
    check("bp_idle_ready", 64'(bus.query_ready_out), 64'(1));
    check("bp_idle_valid", 64'(bus.result_valid_out), 64'(0));
    issue_query(77, 88, 1, 1, 1'b1, 1'b1, 0, 4'b0001, 4, acc);
    check("bp_accept_cycle", 64'(acc), 64'(d + 2));
    wait_idle(40);

    // Reset while issuing, checker answering 1 throughout.
    @(negedge clk);
    hits      = 4'b0000;
    force_hit = 1'b1;
    issue_query(1000, -2000, 4, 2, 1'b0, 1'b0, 0, 4'b0000, 0, acc);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    force_hit = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    check("rst_pending_reqs", 64'(exp_req.size()), 64'(0));
    check("rst_no_result", 64'(bus.result_valid_out), 64'(0));
    issue_query(5, 6, 2, 2, 1'b1, 1'b0, 0, 4'b0000, 5, acc);
    wait_idle(40);

    @(negedge clk);
    #2;
    check("final_req_queue", 64'(exp_req.size()), 64'(0));
    check("final_res_queue", 64'(exp_res.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
